// File: rtl/halt_step_controller.sv
`default_nettype none
// halt_step_controller: CPU halt/continue run controller with debounced button,
// optional auto-resume and a hold-until-acknowledged continue handshake. Rev 1.0
module halt_step_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_DELAY      = 0,
  parameter int ACK_TIMEOUT     = 1024,
  parameter int HALT_COUNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_continue,
  input  logic                    auto_en,
  input  logic                    halted,
  input  logic                    pwr,
  input  logic [31:0]             debug,
  output logic                    cont_out,
  output logic [31:0]             snap,
  output logic                    snap_valid,
  output logic [HALT_COUNT_W-1:0] halt_count,
  output logic                    ack_err,
  output logic [1:0]              state
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int ATW = $clog2(AUTO_DELAY + 2);
  localparam int ACW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ATW-1:0] AUTO_LAST = ATW'(AUTO_DELAY);
  localparam logic [ACW-1:0] ACK_LAST  = ACW'(ACK_TIMEOUT - 1);
  localparam bit             AUTO_ON   = (AUTO_DELAY != 0);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  logic           sync1_q, sync2_q, level_q, level_prev_q, press_q;
  logic [DBW-1:0] db_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= btn_continue;
      sync2_q      <= sync1_q;
      if (sync2_q == level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        level_q  <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DBW'(1);
      end
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  state_e                  state_q, state_d;
  logic                    cont_q, cont_d;
  logic [31:0]             snap_q, snap_d;
  logic                    valid_q, valid_d;
  logic [HALT_COUNT_W-1:0] count_q, count_d;
  logic                    err_q, err_d;
  logic [ATW-1:0]          auto_cnt_q, auto_cnt_d;
  logic [ACW-1:0]          ack_cnt_q, ack_cnt_d;
  logic                    auto_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      cont_q     <= 1'b0;
      snap_q     <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
      auto_cnt_q <= '0;
      ack_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cont_q     <= cont_d;
      snap_q     <= snap_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      err_q      <= err_d;
      auto_cnt_q <= auto_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cont_d     = cont_q;
    snap_d     = snap_q;
    valid_d    = valid_q;
    count_d    = count_q;
    err_d      = err_q;
    auto_cnt_d = auto_cnt_q;
    ack_cnt_d  = ack_cnt_q;
    auto_fire  = AUTO_ON && auto_en && (auto_cnt_q == AUTO_LAST);

    // Power loss overrides everything, including a halt capture this cycle.
    if (!pwr) begin
      state_d = S_DONE;
      cont_d  = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (halted) begin
            snap_d     = debug;
            valid_d    = 1'b1;
            count_d    = (count_q == '1) ? count_q : count_q + HALT_COUNT_W'(1);
            auto_cnt_d = '0;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (press_q || auto_fire) begin
            cont_d    = 1'b1;
            ack_cnt_d = '0;
            state_d   = S_ACK;
          end else if (AUTO_ON && auto_en) begin
            auto_cnt_d = auto_cnt_q + ATW'(1);
          end
        end
        S_ACK: begin
          if (!halted) begin
            cont_d  = 1'b0;
            state_d = S_RUN;
          end else if (ack_cnt_q == ACK_LAST) begin
            cont_d     = 1'b0;
            err_d      = 1'b1;
            auto_cnt_d = '0;
            state_d    = S_WAIT;
          end else begin
            ack_cnt_d = ack_cnt_q + ACW'(1);
          end
        end
        default: begin
          cont_d = 1'b0;
        end
      endcase
    end
  end

  assign cont_out   = cont_q;
  assign snap       = snap_q;
  assign snap_valid = valid_q;
  assign halt_count = count_q;
  assign ack_err    = err_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_halt_step_controller.sv
`default_nettype none
// tb_halt_step_controller: scoreboard bench; expected cont_out edges are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_halt_step_controller;

  localparam logic [1:0] ST_RUN = 2'd0, ST_WAIT = 2'd1, ST_ACK = 2'd2, ST_DONE = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        a_reset, a_btn, a_auto_en, a_halted, a_pwr;
  logic [31:0] a_debug, a_snap;
  logic        a_cont, a_valid, a_err;
  logic [15:0] a_hc;
  logic [1:0]  a_state;

  logic        b_reset, b_halted;
  logic        b_btn = 1'b0, b_auto_en = 1'b1, b_pwr = 1'b1;
  logic [31:0] b_debug, b_snap;
  logic        b_cont, b_valid, b_err;
  logic [7:0]  b_hc;
  logic [1:0]  b_state;

  halt_step_controller #(
    .DEBOUNCE_CYCLES(4), .AUTO_DELAY(10), .ACK_TIMEOUT(16)
  ) dut_a (
    .clk(clk), .reset(a_reset), .btn_continue(a_btn), .auto_en(a_auto_en),
    .halted(a_halted), .pwr(a_pwr), .debug(a_debug), .cont_out(a_cont),
    .snap(a_snap), .snap_valid(a_valid), .halt_count(a_hc), .ack_err(a_err),
    .state(a_state)
  );

  halt_step_controller #(
    .DEBOUNCE_CYCLES(2), .AUTO_DELAY(1), .ACK_TIMEOUT(4), .HALT_COUNT_W(8)
  ) dut_b (
    .clk(clk), .reset(b_reset), .btn_continue(b_btn), .auto_en(b_auto_en),
    .halted(b_halted), .pwr(b_pwr), .debug(b_debug), .cont_out(b_cont),
    .snap(b_snap), .snap_valid(b_valid), .halt_count(b_hc), .ack_err(b_err),
    .state(b_state)
  );

  typedef struct {
    bit          rise;
    int          at;
    logic [31:0] snap;
    logic [15:0] hc;
    logic        err;
    logic [1:0]  st;
  } ev_t;
  ev_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_edge(input bit rise, input int at, input logic [31:0] s,
                             input logic [15:0] h, input logic e, input logic [1:0] st);
    ev_t x;
    x.rise = rise; x.at = at; x.snap = s; x.hc = h; x.err = e; x.st = st;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every cont_out edge of dut_a must match the next queued expectation.
  initial begin
    logic prev;
    ev_t  e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (a_cont !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cont_edge: cont_out=%0b at cycle %0d, none required", a_cont, cyc);
        end else begin
          e = sb.pop_front();
          chk("edge_dir",   32'(a_cont),  32'(e.rise));
          chk("edge_cycle", cyc,          e.at);
          chk("edge_snap",  a_snap,       e.snap);
          chk("edge_count", 32'(a_hc),    32'(e.hc));
          chk("edge_err",   32'(a_err),   32'(e.err));
          chk("edge_state", 32'(a_state), 32'(e.st));
        end
      end
      prev = a_cont;
    end
  end

  initial begin
    int t;
    a_reset = 1'b0; a_btn = 1'b0; a_auto_en = 1'b0; a_halted = 1'b0; a_pwr = 1'b1;
    a_debug = 32'd0;
    b_reset = 1'b0; b_halted = 1'b0; b_debug = 32'd0;
    tick(3);
    chk("rst_cont",  32'(a_cont),  32'd0);
    chk("rst_snap",  a_snap,       32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_count", 32'(a_hc),    32'd0);
    chk("rst_err",   32'(a_err),   32'd0);
    chk("rst_state", 32'(a_state), 32'(ST_RUN));
    a_reset = 1'b1; b_reset = 1'b1;
    tick(2);

    // Halt capture, then a bounced press producing one continue.
    a_halted = 1'b1; a_debug = 32'hDEADBEEF;
    tick(2);
    chk("cap1_snap",  a_snap,       32'hDEADBEEF);
    chk("cap1_valid", 32'(a_valid), 32'd1);
    chk("cap1_count", 32'(a_hc),    32'd1);
    chk("cap1_state", 32'(a_state), 32'(ST_WAIT));
    t = cyc;
    expect_edge(1'b1, t + 10, 32'hDEADBEEF, 16'd1, 1'b0, ST_ACK);
    expect_edge(1'b0, t + 16, 32'hDEADBEEF, 16'd1, 1'b0, ST_RUN);
    a_btn = 1'b1; tick(1);
    a_btn = 1'b0; tick(1);
    a_btn = 1'b1; tick(13);
    a_halted = 1'b0; tick(1);
    chk("hs_state", 32'(a_state), 32'(ST_RUN));
    // Re-halt in the very first RUN cycle.
    a_halted = 1'b1; a_debug = 32'h12; tick(1);
    chk("cap2_snap",  a_snap,       32'h12);
    chk("cap2_count", 32'(a_hc),    32'd2);
    chk("cap2_state", 32'(a_state), 32'(ST_WAIT));
    tick(5);
    a_btn = 1'b0; tick(12);

    // auto_en=0: no continue for 100 cycles.
    tick(100);
    chk("noauto_cont",  32'(a_cont),  32'd0);
    chk("noauto_state", 32'(a_state), 32'(ST_WAIT));

    // Acknowledge timeout, then a later press still works with ack_err sticky.
    t = cyc;
    expect_edge(1'b1, t + 8,  32'h12, 16'd2, 1'b0, ST_ACK);
    expect_edge(1'b0, t + 24, 32'h12, 16'd2, 1'b1, ST_WAIT);
    a_btn = 1'b1; tick(10);
    a_btn = 1'b0; tick(20);
    chk("to_err",   32'(a_err),   32'd1);
    chk("to_state", 32'(a_state), 32'(ST_WAIT));
    t = cyc;
    expect_edge(1'b1, t + 8,  32'h12, 16'd2, 1'b1, ST_ACK);
    expect_edge(1'b0, t + 11, 32'h12, 16'd2, 1'b1, ST_RUN);
    a_btn = 1'b1; tick(10);
    a_halted = 1'b0; a_btn = 1'b0; tick(12);

    // A press while running is discarded, not queued for the next halt.
    a_btn = 1'b1; tick(12);
    a_btn = 1'b0; tick(12);
    a_halted = 1'b1; a_debug = 32'h34; tick(20);
    chk("discard_cont",  32'(a_cont),  32'd0);
    chk("discard_state", 32'(a_state), 32'(ST_WAIT));
    t = cyc;
    expect_edge(1'b1, t + 8,  32'h34, 16'd3, 1'b1, ST_ACK);
    expect_edge(1'b0, t + 10, 32'h34, 16'd3, 1'b1, ST_RUN);
    a_btn = 1'b1; tick(9);
    a_halted = 1'b0; a_btn = 1'b0; tick(12);

    // Auto resume: continue 11 cycles after the WAIT-entry edge.
    a_auto_en = 1'b1;
    t = cyc;
    expect_edge(1'b1, t + 12, 32'h55, 16'd4, 1'b1, ST_ACK);
    expect_edge(1'b0, t + 14, 32'h55, 16'd4, 1'b1, ST_RUN);
    a_halted = 1'b1; a_debug = 32'h55; tick(13);
    a_halted = 1'b0; a_auto_en = 1'b0; tick(2);

    // Reset during ACK drops cont_out without a clock edge.
    t = cyc;
    expect_edge(1'b1, t + 9,  32'h77, 16'd5, 1'b1, ST_ACK);
    expect_edge(1'b0, t + 11, 32'h0,  16'd0, 1'b0, ST_RUN);
    a_halted = 1'b1; a_debug = 32'h77; tick(1);
    a_btn = 1'b1; tick(10);
    a_reset = 1'b0; #1;
    chk("arst_cont",  32'(a_cont),  32'd0);
    chk("arst_count", 32'(a_hc),    32'd0);
    chk("arst_err",   32'(a_err),   32'd0);
    chk("arst_state", 32'(a_state), 32'(ST_RUN));
    a_btn = 1'b0; a_halted = 1'b0; tick(2);
    a_reset = 1'b1; tick(10);

    // Power-down in the same cycle as a halt: DONE wins, no capture.
    a_halted = 1'b1; a_pwr = 1'b0; a_debug = 32'h99; tick(1);
    chk("pd_state", 32'(a_state), 32'(ST_DONE));
    chk("pd_count", 32'(a_hc),    32'd0);
    chk("pd_valid", 32'(a_valid), 32'd0);
    chk("pd_snap",  a_snap,       32'd0);
    a_pwr = 1'b1; a_halted = 1'b0; a_btn = 1'b1; tick(20);
    a_btn = 1'b0; a_halted = 1'b1; tick(20);
    chk("pd_hold_state", 32'(a_state), 32'(ST_DONE));
    chk("pd_hold_cont",  32'(a_cont),  32'd0);
    a_reset = 1'b0; #1;
    chk("pd_rst_state", 32'(a_state), 32'(ST_RUN));
    chk("pd_rst_cont",  32'(a_cont),  32'd0);
    chk("pd_rst_valid", 32'(a_valid), 32'd0);
    a_halted = 1'b0; tick(2);
    a_reset = 1'b1; tick(2);

    // Saturation on the narrow-counter instance: 4 cycles per halt/continue.
    for (int i = 1; i <= 257; i++) begin
      b_halted = 1'b1; b_debug = 32'(i); tick(3);
      b_halted = 1'b0; tick(1);
      if (i == 254) chk("sat_254", 32'(b_hc), 32'hFE);
      if (i == 255) chk("sat_255", 32'(b_hc), 32'hFF);
    end
    chk("sat_final", 32'(b_hc),    32'hFF);
    chk("sat_snap",  b_snap,       32'd257);
    chk("sat_state", 32'(b_state), 32'(ST_RUN));
    chk("sat_err",   32'(b_err),   32'd0);

    tick(4);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
